// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Instruction-fetch sequencer. Owns the PC, captures {pc, inst}
//            into a prefetch FIFO and hands entries to decode via valid/ready.
// Options  : FETCH_MISALIGN_TRAP_EN - trap misaligned redirect targets.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              INST_WIDTH = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              DEPTH      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_halt,
    input  logic                  i_redirect,
    input  logic [XLEN-1:0]       i_redirect_pc,
    output logic [XLEN-1:0]       o_imem_addr,
    input  logic [INST_WIDTH-1:0] i_imem_inst,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [XLEN-1:0]       o_pc,
    output logic                  o_misaligned
);

    localparam int              C_PW    = $clog2(DEPTH);
    localparam int              C_CW    = C_PW + 1;
    localparam logic [C_CW-1:0] C_DEPTH = C_CW'(DEPTH);
    localparam logic [XLEN-1:0] C_STEP  = XLEN'(4);

    logic [XLEN-1:0]       pc_q, pc_d;
    logic [C_PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [C_PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [C_CW-1:0]       count_q, count_d;
    logic [XLEN-1:0]       fifo_pc_q   [DEPTH];
    logic [INST_WIDTH-1:0] fifo_inst_q [DEPTH];

    logic                  w_pop;
    logic                  w_push;
    logic                  w_stopped;
    logic [XLEN-1:0]       w_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic stopped_q;
    logic misaligned_q;
    logic w_misalign;

    assign w_misalign   = |i_redirect_pc[1:0];
    assign w_target     = i_redirect_pc;
    assign w_stopped    = stopped_q;
    assign o_misaligned = misaligned_q;

    // Every redirect re-evaluates the trap: misaligned sets it, aligned clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stopped_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else if (i_redirect) begin
            stopped_q    <= w_misalign;
            misaligned_q <= w_misalign;
        end
    end
`else
    logic w_unused_low_bits;

    assign w_unused_low_bits = ^i_redirect_pc[1:0];
    assign w_target          = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign w_stopped         = 1'b0;
    assign o_misaligned      = 1'b0;
`endif

    assign w_pop  = (count_q != '0) & i_ready & ~i_redirect;
    assign w_push = ~i_redirect & ~i_halt & ~w_stopped & ((count_q < C_DEPTH) | w_pop);

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_redirect) begin
            // Flush realigns both pointers so the next push becomes the head.
            pc_d     = w_target;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                pc_d     = pc_q + C_STEP;
                wr_ptr_d = wr_ptr_q + C_PW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PW'(1);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + C_CW'(1);
            end else if (!w_push && w_pop) begin
                count_d = count_q - C_CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q     <= RESET_VEC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            fifo_pc_q[wr_ptr_q]   <= pc_q;
            fifo_inst_q[wr_ptr_q] <= i_imem_inst;
        end
    end

    assign o_imem_addr = pc_q;
    assign o_valid     = (count_q != '0);
    assign o_pc        = o_valid ? fifo_pc_q[rd_ptr_q]   : '0;
    assign o_inst      = o_valid ? fifo_inst_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Directed self-checking bench for fetch_ctrl (DEPTH=2, mem[i]=i+1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        r_clk;
    logic        r_rst_n;
    logic        r_halt;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic        r_ready;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_inst;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic        w_misaligned;

    int n_cmp;
    int n_err;

    // Instruction memory model: word i holds i+1.
    assign w_imem_inst = (w_imem_addr >> 2) + 32'd1;

    fetch_ctrl #(
        .XLEN       (32),
        .INST_WIDTH (32),
        .RESET_VEC  (32'h0000_0000),
        .DEPTH      (2)
    ) u_dut (
        .i_clk         (r_clk),
        .i_rst_n       (r_rst_n),
        .i_halt        (r_halt),
        .i_redirect    (r_redirect),
        .i_redirect_pc (r_redirect_pc),
        .o_imem_addr   (w_imem_addr),
        .i_imem_inst   (w_imem_inst),
        .o_valid       (w_valid),
        .i_ready       (r_ready),
        .o_inst        (w_inst),
        .o_pc          (w_pc),
        .o_misaligned  (w_misaligned)
    );

    initial begin
        r_clk = 1'b0;
        forever #5 r_clk = ~r_clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge r_clk);
            #1;
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check_eq({tag, ".valid"}, 64'(w_valid), 64'd1);
        check_eq({tag, ".pc"},    64'(w_pc),    64'(pc));
        check_eq({tag, ".inst"},  64'(w_inst),  64'((pc >> 2) + 32'd1));
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        r_rst_n       = 1'b0;
        r_halt        = 1'b0;
        r_redirect    = 1'b0;
        r_redirect_pc = 32'h0;
        r_ready       = 1'b1;

        // Reset state
        step(2);
        check_eq("rst.valid", 64'(w_valid),      64'd0);
        check_eq("rst.addr",  64'(w_imem_addr),  64'h0);
        check_eq("rst.pc",    64'(w_pc),         64'h0);
        check_eq("rst.inst",  64'(w_inst),       64'h0);
        check_eq("rst.mis",   64'(w_misaligned), 64'd0);
        r_rst_n = 1'b1;

        // 1. Streaming, one entry per cycle
        for (int k = 0; k < 4; k++) begin
            step(1);
            check_head($sformatf("stream%0d", k), 32'(4 * k));
        end
        check_eq("stream.addr", 64'(w_imem_addr), 64'h10);

        // 2. Back-pressure: fill to DEPTH, pc holds, then in-order drain
        r_ready = 1'b0;
        step(5);
        check_head("bp.hold", 32'h0C);
        check_eq("bp.addr", 64'(w_imem_addr), 64'h14);
        r_ready = 1'b1;
        step(1); check_head("bp.r0", 32'h10);
        step(1); check_head("bp.r1", 32'h14);
        step(1); check_head("bp.r2", 32'h18);

        // 3. Redirect with a full FIFO
        r_redirect    = 1'b1;
        r_redirect_pc = 32'h40;
        step(1);
        r_redirect = 1'b0;
        check_eq("rd.valid", 64'(w_valid),     64'd0);
        check_eq("rd.addr",  64'(w_imem_addr), 64'h40);
        check_eq("rd.pc0",   64'(w_pc),        64'h0);
        step(1); check_head("rd.h0", 32'h40);
        step(1); check_head("rd.h1", 32'h44);

        // 4. PC wrap-around
        r_redirect    = 1'b1;
        r_redirect_pc = 32'hFFFF_FFF8;
        step(1);
        r_redirect = 1'b0;
        step(1); check_head("wrap0", 32'hFFFF_FFF8);
        step(1); check_head("wrap1", 32'hFFFF_FFFC);
        step(1); check_head("wrap2", 32'h0000_0000);

        // 5. Halt with two entries queued
        r_ready = 1'b0;
        step(2);
        check_eq("halt.fill", 64'(w_imem_addr), 64'h8);
        r_halt  = 1'b1;
        r_ready = 1'b1;
        step(1); check_head("halt.d0", 32'h4);
        step(1);
        check_eq("halt.empty", 64'(w_valid),     64'd0);
        check_eq("halt.addr",  64'(w_imem_addr), 64'h8);
        step(1);
        check_eq("halt.frz",   64'(w_imem_addr), 64'h8);
        r_halt = 1'b0;
        step(1); check_head("halt.res", 32'h8);

        // 6. Misaligned redirect
        r_redirect    = 1'b1;
        r_redirect_pc = 32'h42;
        step(1);
        r_redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("mis.flag",  64'(w_misaligned), 64'd1);
        check_eq("mis.valid", 64'(w_valid),      64'd0);
        step(2);
        check_eq("mis.stay",  64'(w_valid),      64'd0);
        check_eq("mis.addr",  64'(w_imem_addr),  64'h42);
        r_redirect    = 1'b1;
        r_redirect_pc = 32'h80;
        step(1);
        r_redirect = 1'b0;
        check_eq("mis.clr", 64'(w_misaligned), 64'd0);
        step(1); check_head("mis.h", 32'h80);
`else
        check_eq("mis.flag", 64'(w_misaligned), 64'd0);
        check_eq("mis.addr", 64'(w_imem_addr),  64'h40);
        step(1); check_head("mis.h", 32'h40);
`endif

        // Asynchronous reset mid-stream
        step(1);
        r_rst_n = 1'b0;
        #1;
        check_eq("arst.valid", 64'(w_valid),     64'd0);
        check_eq("arst.addr",  64'(w_imem_addr), 64'h0);
        check_eq("arst.pc",    64'(w_pc),        64'h0);
        step(1);
        r_rst_n = 1'b1;
        step(1); check_head("arst.h0", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
